hazard_scoreboard: RTL and testbench

//  Parametrised decode-stage hazard unit. Tracks in-flight register writers in a

---
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 tb/tb_hazard_scoreboard.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: tracks in-flight writers, flags per-operand stalls, selects forwarding slots.
// Latency: stall/forward outputs are combinational from tracked slots and decode inputs; slot state advances each posedge.
// Backpressure: hold freezes all state; a stall shifts a bubble into slot 0 and counts the stall cycle.
//
// Ports: clk/rst (sync, active high); hold, flush; id_* describe the decode instruction
// (operand reads, early-need flag, destination write and its forwardable slot);
// stall/stall_src1/stall_src2, fwd1_hit/fwd1_slot, fwd2_hit/fwd2_slot, stall_cnt (saturating).
module hazard_scoreboard #(
   parameter int REG_W      = 3,
   parameter int DEPTH      = 3,
   parameter int SW         = 2,
   parameter int EARLY_NEED = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             flush,
   input  logic             id_valid,
   input  logic             id_rd1_en,
   input  logic [REG_W-1:0] id_rs1,
   input  logic             id_rd2_en,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_early,
   input  logic             id_wr_en,
   input  logic [REG_W-1:0] id_wd,
   input  logic [SW-1:0]    id_ready_at,
   output logic             stall,
   output logic             stall_src1,
   output logic             stall_src2,
   output logic             fwd1_hit,
   output logic [SW-1:0]    fwd1_slot,
   output logic             fwd2_hit,
   output logic [SW-1:0]    fwd2_slot,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [SW-1:0] NEED_EARLY = SW'(EARLY_NEED);

   logic             slot_v    [DEPTH];
   logic [REG_W-1:0] slot_dest [DEPTH];
   logic [SW-1:0]    slot_ra   [DEPTH];

   logic          match1, match2;
   logic [SW-1:0] m1, m2, ra1, ra2, need, thr1, thr2;

   // Scan oldest to youngest so the youngest matching writer wins.
   always_comb begin
      match1 = 1'b0;
      m1     = '0;
      ra1    = '0;
      match2 = 1'b0;
      m2     = '0;
      ra2    = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (slot_v[i] && slot_dest[i] == id_rs1) begin
            match1 = 1'b1;
            m1     = SW'(i);
            ra1    = slot_ra[i];
         end
         if (slot_v[i] && slot_dest[i] == id_rs2) begin
            match2 = 1'b1;
            m2     = SW'(i);
            ra2    = slot_ra[i];
         end
      end
   end

   // The operand is usable once the writer has reached both the slot where
   // its result exists and the slot where this consumer needs it.
   always_comb begin
      need       = id_early ? NEED_EARLY : '0;
      thr1       = (ra1 > need) ? ra1 : need;
      thr2       = (ra2 > need) ? ra2 : need;
      stall_src1 = id_valid && id_rd1_en && match1 && (m1 < thr1);
      stall_src2 = id_valid && id_rd2_en && match2 && (m2 < thr2);
      stall      = stall_src1 || stall_src2;
      fwd1_hit   = id_valid && id_rd1_en && match1 && !stall_src1;
      fwd2_hit   = id_valid && id_rd2_en && match2 && !stall_src2;
      fwd1_slot  = fwd1_hit ? m1 : '0;
      fwd2_slot  = fwd2_hit ? m2 : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_v[i] <= 1'b0;
         end
         stall_cnt <= '0;
      end else if (!hold) begin
         for (int i = 1; i < DEPTH; i++) begin
            slot_v[i]    <= slot_v[i-1];
            slot_dest[i] <= slot_dest[i-1];
            slot_ra[i]   <= slot_ra[i-1];
         end
         // A stalled or flushed decode instruction enters as a bubble.
         slot_v[0]    <= id_valid && id_wr_en && !stall && !flush;
         slot_dest[0] <= id_wd;
         slot_ra[0]   <= id_ready_at;
         if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

   a_ready_at_legal: assert property (@(posedge clk) disable iff (rst)
      (id_valid && id_wr_en) |-> (int'(id_ready_at) < DEPTH));

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

   localparam int REG_W = 3;
   localparam int DEPTH = 3;
   localparam int SW    = 2;
   localparam int EN    = 2;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0, hold = 1'b0, flush = 1'b0;
   logic             id_valid = 1'b0, id_rd1_en = 1'b0, id_rd2_en = 1'b0;
   logic             id_early = 1'b0, id_wr_en = 1'b0;
   logic [REG_W-1:0] id_rs1 = '0, id_rs2 = '0, id_wd = '0;
   logic [SW-1:0]    id_ready_at = '0;
   logic             stall, stall_src1, stall_src2, fwd1_hit, fwd2_hit;
   logic [SW-1:0]    fwd1_slot, fwd2_slot;
   logic [CNT_W-1:0] stall_cnt;

   hazard_scoreboard #(.REG_W(REG_W), .DEPTH(DEPTH), .SW(SW), .EARLY_NEED(EN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush),
      .id_valid(id_valid), .id_rd1_en(id_rd1_en), .id_rs1(id_rs1),
      .id_rd2_en(id_rd2_en), .id_rs2(id_rs2), .id_early(id_early),
      .id_wr_en(id_wr_en), .id_wd(id_wd), .id_ready_at(id_ready_at),
      .stall(stall), .stall_src1(stall_src1), .stall_src2(stall_src2),
      .fwd1_hit(fwd1_hit), .fwd1_slot(fwd1_slot),
      .fwd2_hit(fwd2_hit), .fwd2_slot(fwd2_slot), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit chk;
      int st, s1, s2, h1, h2, f1, f2, cnt;
   } exp_t;

   // Model: in-flight writers ordered by age, index 0 = just left decode.
   typedef struct {
      bit v;
      int dest;
      int ra;
   } ent_t;

   exp_t expq[$];
   ent_t pipe[$];
   int   cnt_m = 0;
   bit   known = 1'b0;
   int   checks = 0;
   int   failures = 0;
   bit   drv_done = 1'b0;

   function automatic void operand(input bit en, input int rs, input bit early,
                                   output int st, output int hit, output int slot);
      int need, thr;
      st = 0; hit = 0; slot = 0;
      need = early ? EN : 0;
      if (!(id_valid && en)) return;
      for (int k = 0; k < pipe.size(); k++) begin
         if (pipe[k].v && pipe[k].dest == rs) begin
            thr = (pipe[k].ra > need) ? pipe[k].ra : need;
            if (k < thr) st = 1;
            else begin hit = 1; slot = k; end
            return;
         end
      end
   endfunction

   task automatic step(input bit r, input bit h, input bit f, input bit v,
                       input bit e1, input int s1, input bit e2, input int s2,
                       input bit early, input bit we, input int wd, input int ra);
      exp_t e;
      ent_t n;
      @(negedge clk);
      rst = r; hold = h; flush = f; id_valid = v;
      id_rd1_en = e1; id_rs1 = REG_W'(s1); id_rd2_en = e2; id_rs2 = REG_W'(s2);
      id_early = early; id_wr_en = we; id_wd = REG_W'(wd); id_ready_at = SW'(ra);
      e.chk = known;
      operand(e1, s1, early, e.s1, e.h1, e.f1);
      operand(e2, s2, early, e.s2, e.h2, e.f2);
      e.st  = e.s1 | e.s2;
      e.cnt = cnt_m;
      expq.push_back(e);
      @(posedge clk);
      if (r) begin
         pipe.delete();
         for (int k = 0; k < DEPTH; k++) begin
            n.v = 0; n.dest = 0; n.ra = 0;
            pipe.push_back(n);
         end
         cnt_m = 0;
         known = 1'b1;
      end else if (!h && known) begin
         n.v = v && we && !e.st && !f;
         n.dest = wd;
         n.ra = ra;
         pipe.push_front(n);
         void'(pipe.pop_back());
         if (e.st && cnt_m < CMAX) cnt_m++;
      end
   endtask

   // Decode-only helpers for the directed scenarios.
   task automatic idle(); step(0,0,0,0, 0,0,0,0, 0,0,0,0); endtask
   task automatic wr(input int wd, input int ra); step(0,0,0,1, 0,0,0,0, 0,1,wd,ra); endtask
   task automatic rd1(input int rs, input bit early, input bit h);
      step(0,h,0,1, 1,rs,0,0, early,0,0,0);
   endtask

   task automatic cmp(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per presented decode cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            if (e.chk) begin
               cmp("stall",      int'(stall),      e.st);
               cmp("stall_src1", int'(stall_src1), e.s1);
               cmp("stall_src2", int'(stall_src2), e.s2);
               cmp("fwd1_hit",   int'(fwd1_hit),   e.h1);
               cmp("fwd1_slot",  int'(fwd1_slot),  e.f1);
               cmp("fwd2_hit",   int'(fwd2_hit),   e.h2);
               cmp("fwd2_slot",  int'(fwd2_slot),  e.f2);
               cmp("stall_cnt",  int'(stall_cnt),  e.cnt);
            end
         end
      end
   end

   initial begin
      step(1,0,0,0, 0,0,0,0, 0,0,0,0);
      idle();
      // Load-use: one stall, then forward from slot 1.
      wr(3, 1); rd1(3, 0, 0); rd1(3, 0, 0); idle(); idle();
      // Early consumer behind an ALU writer: two stalls, then slot 2.
      wr(2, 0); rd1(2, 1, 0); rd1(2, 1, 0); rd1(2, 1, 0); idle(); idle();
      // Youngest writer wins over an older load.
      wr(5, 1); wr(5, 0); rd1(5, 0, 0); idle(); idle();
      // Hold freezes a load-use stall for three cycles.
      wr(3, 1); rd1(3, 0, 1); rd1(3, 0, 1); rd1(3, 0, 1); rd1(3, 0, 0); rd1(3, 0, 0);
      idle(); idle();
      // Flushed writer never enters the slots.
      step(0,0,1,1, 0,0,0,0, 0,1,4,0); rd1(4, 0, 0); idle(); idle();
      // Flush while stalled.
      wr(6, 1); step(0,0,1,1, 1,6,0,0, 0,1,1,0); rd1(1, 0, 0); idle(); idle();
      // Reset in the middle of a stall.
      wr(3, 1); rd1(3, 0, 0); step(1,0,0,1, 1,3,0,0, 0,0,0,0); rd1(3, 0, 0); idle();
      // Saturation: ten early-branch hazards of two stalls each.
      for (int i = 0; i < 10; i++) begin
         wr(2, 0); rd1(2, 1, 0); rd1(2, 1, 0); rd1(2, 1, 0);
      end
      idle(); idle();
      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 79) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
              $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 7),
              ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 2));
      end
      idle();
      drv_done = 1'b1;
   end

   initial begin
      wait (drv_done == 1'b1 || $time > 200000);
      repeat (2) @(negedge clk);
      #3;
      cmp("queue_drained", expq.size(), 0);
      cmp("driver_done", int'(drv_done), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
